// File: rtl/grid_scan_pkg.sv
// grid_scan_pkg: shared geometry and FSM state type for the LED matrix scanner.
//   ROWS/COLS  matrix dimensions; GRID_W = ROWS*COLS grid bits.
//   scan_state_t  IDLE / LOAD / BLANK / DRIVE.
package grid_scan_pkg;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GRID_W = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter shared by the BLANK and DRIVE phases.
//   clk_i       clock
//   rst_i       synchronous active-high reset (counter to 0)
//   load_i      load load_val_i this cycle (wins over counting)
//   load_val_i  value loaded; a phase of N cycles loads N-1
//   cnt_o       current count
//   done_o      high while the count is 0 (last cycle of the phase)
module scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)              cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/grid_matrix_scan.sv
// grid_matrix_scan: row-multiplexed 8x8 LED driver for the Game-of-Life grid.
// New generations land in a pending buffer and are copied to the displayed
// shadow only in the LOAD cycle at a frame boundary, so a frame never tears.
// Optional feature macro: GRID_SCAN_PWM_EN (adds brightness port, gates col_data).
//   clka        clock
//   stop        synchronous active-high reset
//   enable      scanning allowed
//   grid        current generation, bit 8*r+c = row r, column c
//   grid_valid  one-cycle strobe: grid holds a new generation
//   brightness  duty select (GRID_SCAN_PWM_EN only)
//   row_sel     one-hot row drive, 0 = all rows off
//   col_data    column drive for the active row
//   scan_row    row currently being scanned
//   frame_done  one-cycle pulse after row 7 finishes its dwell
module grid_matrix_scan
  import grid_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic              clka,
  input  logic              stop,
  input  logic              enable,
  input  logic [GRID_W-1:0] grid,
  input  logic              grid_valid,
`ifdef GRID_SCAN_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_data,
  output logic [2:0]        scan_row,
  output logic              frame_done
);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DW_LD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit            NO_BLANK = (BLANK_CYCLES == 0);
  localparam logic [2:0]    LAST_ROW = 3'(ROWS - 1);

  scan_state_t       state_q;
  logic [2:0]        row_q, row_nxt;
  logic [GRID_W-1:0] shadow_q, pend_q, shadow_nxt;
  logic              pending_q;
  logic [ROWS-1:0]   row_sel_q;
  logic [COLS-1:0]   col_q;
  logic              frame_done_q;

  logic [CW-1:0]     tmr_cnt, tmr_val;
  logic              tmr_done, tmr_load;

  // Timer reloads on every entry into BLANK or DRIVE.
  always_comb begin
    row_nxt    = row_q + 3'd1;
    shadow_nxt = pending_q ? pend_q : shadow_q;
    tmr_load   = 1'b0;
    tmr_val    = DW_LD;
    if (enable) begin
      case (state_q)
        LOAD: begin
          tmr_load = 1'b1;
          tmr_val  = NO_BLANK ? DW_LD : BL_LD;
        end
        BLANK: if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = DW_LD;
        end
        DRIVE: if (tmr_done && row_q != LAST_ROW) begin
          tmr_load = 1'b1;
          tmr_val  = NO_BLANK ? DW_LD : BL_LD;
        end
        default: ;
      endcase
    end
  end

  scan_timer #(.CW(CW)) u_timer (
    .clk_i      (clka),
    .rst_i      (stop),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clka) begin
    if (stop) begin
      state_q      <= IDLE;
      row_q        <= '0;
      shadow_q     <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      row_sel_q    <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!enable) begin
        // Shadow and pending survive; the scan restarts at LOAD/row 0.
        state_q   <= IDLE;
        row_q     <= '0;
        row_sel_q <= '0;
        col_q     <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= LOAD;
          LOAD: begin
            if (pending_q) begin
              shadow_q  <= pend_q;
              pending_q <= 1'b0;
            end
            row_q <= '0;
            if (NO_BLANK) begin
              state_q   <= DRIVE;
              row_sel_q <= ROWS'(1);
              col_q     <= shadow_nxt[COLS-1:0];
            end else begin
              state_q <= BLANK;
            end
          end
          BLANK: if (tmr_done) begin
            state_q   <= DRIVE;
            row_sel_q <= ROWS'(1) << row_q;
            col_q     <= shadow_q[COLS*row_q +: COLS];
          end
          DRIVE: if (tmr_done) begin
            if (row_q == LAST_ROW) begin
              frame_done_q <= 1'b1;
              state_q      <= LOAD;
              row_sel_q    <= '0;
              col_q        <= '0;
            end else begin
              row_q <= row_nxt;
              if (NO_BLANK) begin
                row_sel_q <= ROWS'(1) << row_nxt;
                col_q     <= shadow_q[COLS*row_nxt +: COLS];
              end else begin
                state_q   <= BLANK;
                row_sel_q <= '0;
                col_q     <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Placed last so a strobe coinciding with LOAD keeps pending set.
      if (grid_valid) begin
        pend_q    <= grid;
        pending_q <= 1'b1;
      end
    end
  end

  assign row_sel    = row_sel_q;
  assign scan_row   = row_q;
  assign frame_done = frame_done_q;

`ifdef GRID_SCAN_PWM_EN
  // Low nibble of the dwell countdown sets the duty slot (zero-extended when narrow).
  logic [3:0] cnt_lo;
  assign cnt_lo   = 4'(tmr_cnt);
  assign col_data = (cnt_lo < brightness) ? col_q : '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^tmr_cnt;
  assign col_data   = col_q;
`endif
endmodule

// File: tb/tb_grid_matrix_scan.sv
module tb_grid_matrix_scan;
`ifdef GRID_SCAN_PWM_EN
  localparam int DW = 32;
`else
  localparam int DW = 4;
`endif
  localparam int BL = 1;
  localparam int RT = BL + DW;        // ticks per row
  localparam int FT = 1 + 8 * RT;     // ticks per frame

  logic        clka = 1'b0;
  logic        stop, enable, grid_valid;
  logic [63:0] grid;
`ifdef GRID_SCAN_PWM_EN
  logic [3:0]  brightness;
`endif
  logic [7:0]  row_sel, col_data;
  logic [2:0]  scan_row;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  grid_matrix_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clka       (clka),
    .stop       (stop),
    .enable     (enable),
    .grid       (grid),
    .grid_valid (grid_valid),
`ifdef GRID_SCAN_PWM_EN
    .brightness (brightness),
`endif
    .row_sel    (row_sel),
    .col_data   (col_data),
    .scan_row   (scan_row),
    .frame_done (frame_done)
  );

  always #5 clka = ~clka;

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifndef GRID_SCAN_PWM_EN
  // Starts in the LOAD cycle. Tick c lands in: blank of row c/RT when c%RT<BL,
  // drive of that row otherwise, and the next LOAD (frame_done) at c=FT-1.
  // Optionally strobes sg into grid so that it is sampled at tick strobe_at.
  task automatic run_frame(input logic [63:0] g, input int nt, input int strobe_at,
                           input logic [63:0] sg);
    logic [7:0] e_rs;
    int r, ph;
    for (int c = 0; c < nt; c++) begin
      if (c == strobe_at) begin
        grid       = sg;
        grid_valid = 1'b1;
      end
      tick();
      grid_valid = 1'b0;
      if (c == FT - 1) begin
        chk("frame_done_end", frame_done, 1);
        chk("row_sel_end", row_sel, 0);
        chk("col_data_end", col_data, 0);
      end else begin
        r  = c / RT;
        ph = c % RT;
        chk("frame_done_mid", frame_done, 0);
        chk("scan_row", scan_row, r);
        if (ph < BL) begin
          chk("row_sel_blank", row_sel, 0);
          chk("col_data_blank", col_data, 0);
        end else begin
          e_rs = 8'd1 << r;
          chk("row_sel_drive", row_sel, e_rs);
          chk("col_data_drive", col_data, g[8*r +: 8]);
        end
      end
    end
  endtask
`endif

  initial begin
    // Reset with random other inputs
    stop = 1'b1;
`ifdef GRID_SCAN_PWM_EN
    brightness = 4'd4;
`endif
    for (int i = 0; i < 3; i++) begin
      enable     = 1'($urandom());
      grid       = {$urandom(), $urandom()};
      grid_valid = 1'($urandom());
      tick();
    end
    chk("rst_row_sel", row_sel, 0);
    chk("rst_col_data", col_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_scan_row", scan_row, 0);

`ifndef GRID_SCAN_PWM_EN
    // Load row-0 pattern while idle, then enable
    stop = 1'b0; enable = 1'b0;
    grid = 64'h0000_0000_0000_00FF; grid_valid = 1'b1;
    tick();
    grid_valid = 1'b0;
    chk("idle_row_sel", row_sel, 0);
    enable = 1'b1;
    tick();                                  // now in LOAD
    chk("load_row_sel", row_sel, 0);
    chk("load_frame_done", frame_done, 0);

    // Frame A shows row 0 only; strobe a new generation during row 3
    run_frame(64'h0000_0000_0000_00FF, FT, 17, 64'hFF00_0000_0000_0000);
    // Frame B shows the new generation (row 7 lit)
    run_frame(64'hFF00_0000_0000_0000, FT, -1, 64'h0);
    // Frame C: strobe coincides with LOAD -> previous shadow still shown
    run_frame(64'hFF00_0000_0000_0000, FT, 0, 64'h0000_0000_00AA_0000);
    // Frame D shows the LOAD-cycle generation; drop enable in row 5 drive
    run_frame(64'h0000_0000_00AA_0000, 28, -1, 64'h0);
    enable = 1'b0;
    tick();
    chk("drop_row_sel", row_sel, 0);
    chk("drop_col_data", col_data, 0);
    chk("drop_frame_done", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_frame_done", frame_done, 0);
      chk("idle_row_sel2", row_sel, 0);
    end
    enable = 1'b1;
    tick();                                  // LOAD
    chk("reen_load_row_sel", row_sel, 0);
    run_frame(64'h0000_0000_00AA_0000, FT, -1, 64'h0);

    // stop mid-frame clears shadow too
    run_frame(64'h0000_0000_00AA_0000, 12, -1, 64'h0);
    stop = 1'b1;
    tick();
    chk("stop_row_sel", row_sel, 0);
    chk("stop_col_data", col_data, 0);
    chk("stop_scan_row", scan_row, 0);
    stop = 1'b0;
    tick();                                  // IDLE -> LOAD
    chk("post_stop_row_sel", row_sel, 0);
    run_frame(64'h0, FT, -1, 64'h0);
`else
    // PWM: brightness 4 of 32 dwell cycles -> 8 lit cycles per row
    begin
      int on_cnt;
      logic [7:0] e_rs;
      stop = 1'b0; enable = 1'b0;
      grid = '1; grid_valid = 1'b1; brightness = 4'd4;
      tick();
      grid_valid = 1'b0;
      enable = 1'b1;
      tick();                                // LOAD
      for (int r = 0; r < 8; r++) begin
        tick();
        chk("pwm_blank_row_sel", row_sel, 0);
        on_cnt = 0;
        e_rs = 8'd1 << r;
        for (int k = 0; k < DW; k++) begin
          tick();
          chk("pwm_row_sel", row_sel, e_rs);
          chk("pwm_col_level", (col_data == 8'h00 || col_data == 8'hFF), 1);
          if (col_data != 8'h00) on_cnt++;
        end
        chk("pwm_on_cycles", on_cnt, 8);
      end
      tick();
      chk("pwm_frame_done", frame_done, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
